// File: rtl/debounce_sched.sv
// Time-multiplexed button debouncer: one shared engine services a single button
// per prescaler tick, producing stable levels plus press/release/long-press pulses.
module debounce_sched #(
    parameter int N_BTN         = 2,
    parameter int TICK_DIV      = 27000,
    parameter int DEBOUNCE_TIME = 3,
    parameter int LONG_TIME     = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_evt,
    output logic [N_BTN-1:0] long_press,
    output logic [2:0]       busy_idx
);

    localparam int PW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] PRESC_LAST = CW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(N_BTN - 1);
    localparam logic [8:0]    DEB_T      = 9'(DEBOUNCE_TIME);
    localparam logic [16:0]   LONG_T     = 17'(LONG_TIME);

    logic [N_BTN-1:0] sync_s1;
    logic [N_BTN-1:0] sync_s2;
    logic [CW-1:0]    presc;
    logic             tick;
    logic [PW-1:0]    ptr;
    logic [7:0]       dcnt [N_BTN];
    logic [15:0]      hcnt [N_BTN];

    logic        smp;
    logic        lv_cur;
    logic        lv_nxt;
    logic        tog;
    logic        hit_long;
    logic [7:0]  d_cur;
    logic [7:0]  d_nxt;
    logic [8:0]  d_inc;
    logic [15:0] h_cur;
    logic [15:0] h_nxt;
    logic [16:0] h_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= btn;
            sync_s2 <= sync_s1;
        end
    end

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc    <= '0;
            ptr      <= '0;
            busy_idx <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                ptr      <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
                busy_idx <= 3'(ptr);
            end
        end
    end

    // Shared engine: the hold counter sees the post-toggle level, so a
    // 0->1 acceptance counts as the first held service.
    always_comb begin
        smp      = sync_s2[ptr];
        lv_cur   = level[ptr];
        d_cur    = dcnt[ptr];
        h_cur    = hcnt[ptr];
        d_inc    = {1'b0, d_cur} + 9'd1;
        h_inc    = {1'b0, h_cur} + 17'd1;
        lv_nxt   = lv_cur;
        d_nxt    = '0;
        tog      = 1'b0;
        h_nxt    = h_cur;
        hit_long = 1'b0;
        if (smp != lv_cur) begin
            if (d_inc == DEB_T) begin
                lv_nxt = ~lv_cur;
                tog    = 1'b1;
            end else begin
                d_nxt = d_inc[7:0];
            end
        end
        if (lv_nxt) begin
            if ({1'b0, h_cur} < LONG_T) begin
                h_nxt    = h_inc[15:0];
                hit_long = (h_inc == LONG_T);
            end
        end else begin
            h_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level       <= '0;
            press       <= '0;
            release_evt <= '0;
            long_press  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt[i] <= '0;
                hcnt[i] <= '0;
            end
        end else begin
            press       <= '0;
            release_evt <= '0;
            long_press  <= '0;
            if (tick) begin
                level[ptr]       <= lv_nxt;
                dcnt[ptr]        <= d_nxt;
                hcnt[ptr]        <= h_nxt;
                press[ptr]       <= tog & lv_nxt;
                release_evt[ptr] <= tog & ~lv_nxt;
                long_press[ptr]  <= hit_long;
            end
        end
    end

endmodule

// File: tb/tb_debounce_sched.sv
// Randomized + directed bench for debounce_sched with an event scoreboard fed
// by a service-level reference model.
module tb_debounce_sched;

    localparam int NB   = 2;
    localparam int TDIV = 4;
    localparam int DEB  = 3;
    localparam int LONG = 8;
    localparam int BLK  = TDIV * NB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn = '0;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] release_evt;
    logic [NB-1:0] long_press;
    logic [2:0]    busy_idx;

    debounce_sched #(
        .N_BTN(NB), .TICK_DIV(TDIV), .DEBOUNCE_TIME(DEB), .LONG_TIME(LONG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .level(level), .press(press),
        .release_evt(release_evt), .long_press(long_press), .busy_idx(busy_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int kind;
        int idx;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  now = 0;
    int  pc [NB];
    int  rc [NB];
    int  lc [NB];

    int  m_cyc, m_nserv, m_busy;
    bit  m_s1 [NB];
    bit  m_s2 [NB];
    bit  m_lvl [NB];
    int  m_d [NB];
    int  m_h [NB];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: one step per rising edge, expressed as service rules.
    initial begin
        forever begin
            @(posedge clk);
            now++;
            if (!rst_n) begin
                m_cyc = 0; m_nserv = 0; m_busy = 0;
                for (int b = 0; b < NB; b++) begin
                    m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_d[b] = 0; m_h[b] = 0;
                end
            end else begin
                if (m_cyc % TDIV == TDIV - 1) begin
                    int  b;
                    b = m_nserv % NB;
                    if (m_s2[b] != m_lvl[b]) begin
                        m_d[b]++;
                        if (m_d[b] == DEB) begin
                            m_lvl[b] = !m_lvl[b];
                            m_d[b]   = 0;
                            q.push_back('{now, m_lvl[b] ? 0 : 1, b});
                        end
                    end else begin
                        m_d[b] = 0;
                    end
                    if (m_lvl[b]) begin
                        if (m_h[b] < LONG) begin
                            m_h[b]++;
                            if (m_h[b] == LONG) q.push_back('{now, 2, b});
                        end
                    end else begin
                        m_h[b] = 0;
                    end
                    m_busy = b;
                    m_nserv++;
                end
                m_cyc++;
                for (int b = 0; b < NB; b++) begin
                    m_s2[b] = m_s1[b];
                    m_s1[b] = btn[b];
                end
            end
        end
    end

    // Monitor: pops expected events and compares against DUT pulses.
    initial begin
        for (int b = 0; b < NB; b++) begin pc[b] = 0; rc[b] = 0; lc[b] = 0; end
        forever begin
            logic [NB-1:0] ep, er, el, ml;
            @(negedge clk);
            ep = '0; er = '0; el = '0;
            while (q.size() > 0 && q[0].cyc <= now) begin
                ev_t e;
                e = q.pop_front();
                if (e.cyc < now) chk("stale_event", e.cyc, now);
                else if (e.kind == 0) ep[e.idx] = 1'b1;
                else if (e.kind == 1) er[e.idx] = 1'b1;
                else el[e.idx] = 1'b1;
            end
            if ((ep | er | el | press | release_evt | long_press) != '0) begin
                chk("press", int'(press), int'(ep));
                chk("release", int'(release_evt), int'(er));
                chk("long_press", int'(long_press), int'(el));
            end
            for (int b = 0; b < NB; b++) ml[b] = m_lvl[b];
            chk("level", int'(level), int'(ml));
            chk("busy_idx", int'(busy_idx), m_busy);
            for (int b = 0; b < NB; b++) begin
                pc[b] += int'(press[b]);
                rc[b] += int'(release_evt[b]);
                lc[b] += int'(long_press[b]);
            end
        end
    end

    task automatic do_reset();
        btn   = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic blk(input logic [NB-1:0] v, input int n);
        btn = v;
        repeat (BLK * n) @(negedge clk);
        #1;
    endtask

    initial begin
        int p0, p1, r0, l0, l1;
        do_reset();

        // Tick spacing and busy_idx alternation
        repeat (8) @(negedge clk);
        chk("busy_after_2nd_tick", int'(busy_idx), 1);
        @(negedge clk);
        chk("busy_holds", int'(busy_idx), 1);
        repeat (3) @(negedge clk);
        chk("busy_after_3rd_tick", int'(busy_idx), 0);

        // Steady press on button 0
        do_reset();
        p0 = pc[0];
        blk(2'b01, 3);
        chk("lvl0_after_3_services", int'(level[0]), 1);
        blk(2'b01, 2);
        chk("press0_count", pc[0] - p0, 1);
        chk("lvl1_stays_low", int'(level[1]), 0);

        // Glitch pattern 1,1,0
        do_reset();
        p0 = pc[0];
        blk(2'b01, 2);
        blk(2'b00, 3);
        chk("glitch_no_toggle", int'(level[0]), 0);
        chk("glitch_no_press", pc[0] - p0, 0);

        // Long hold on button 1
        do_reset();
        p1 = pc[1]; l1 = lc[1];
        blk(2'b10, 12);
        chk("press1_count", pc[1] - p1, 1);
        chk("long1_count", lc[1] - l1, 1);
        blk(2'b10, 4);
        chk("long1_no_repeat", lc[1] - l1, 1);

        // Release then re-arm long press on button 0
        do_reset();
        blk(2'b01, 3);
        chk("lvl0_pressed", int'(level[0]), 1);
        r0 = rc[0];
        blk(2'b00, 3);
        chk("lvl0_released", int'(level[0]), 0);
        chk("release0_count", rc[0] - r0, 1);
        l0 = lc[0];
        blk(2'b01, 12);
        chk("long0_rearmed", lc[0] - l0, 1);

        // Reset mid-debounce
        do_reset();
        blk(2'b01, 2);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_outputs_zero",
            int'({level, press, release_evt, long_press, busy_idx}), 0);
        rst_n = 1'b1;
        blk(2'b01, 2);
        chk("rst_progress_discarded", int'(level[0]), 0);
        blk(2'b01, 1);
        chk("rst_fresh_toggle", int'(level[0]), 1);

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 120; i++) begin
            btn = NB'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            repeat ($urandom_range(1, 24)) @(negedge clk);
        end
        btn = '0;
        repeat (40) @(negedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
